// File: rtl/alarm_unit.sv
// Alarm unit: alarm time and enable setting, ring/snooze control
// and a 1 Hz buzzer drive while ringing.
module alarm_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick1hz,
  input  logic       tick2hz,
  input  logic       sw_set,
  input  logic       sw_inc,
  input  logic       sw_stop,
  input  logic [4:0] dc_hour,
  input  logic [5:0] dc_min,
  input  logic [5:0] dc_sec,
  input  logic       mode,
  output logic [4:0] al_hour,
  output logic [5:0] al_min,
  output logic       al_en,
  output logic [1:0] al_set_pos,
  output logic       ringing,
  output logic       buzzer
);

  typedef enum logic [2:0] {
    IDLE,
    SET_HOUR,
    SET_MIN,
    RING,
    SNOOZE
  } state_t;

  state_t     state;
  logic       match;
  logic       match_d;
  logic       trig;
  logic [5:0] ring_cnt;
  logic [8:0] snz_cnt;
  logic [1:0] snooze_cnt;

  assign match = al_en & ~mode
               & (dc_hour == al_hour)
               & (dc_min == al_min)
               & (dc_sec == 6'd0);

  // Edge rule: one trigger per matching second
  assign trig = match & ~match_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      al_hour    <= '0;
      al_min     <= '0;
      al_en      <= 1'b0;
      al_set_pos <= 2'b00;
      ringing    <= 1'b0;
      buzzer     <= 1'b0;
      match_d    <= 1'b0;
      ring_cnt   <= '0;
      snz_cnt    <= '0;
      snooze_cnt <= '0;
    end else begin
      match_d <= match;
      case (state)
        IDLE: begin
          if (sw_set) begin
            state      <= SET_HOUR;
            al_set_pos <= 2'b10;
          end else if (sw_inc) begin
            al_en <= ~al_en;
          end else if (trig) begin
            state    <= RING;
            ringing  <= 1'b1;
            buzzer   <= 1'b1;
            ring_cnt <= '0;
          end
        end
        SET_HOUR: begin
          if (sw_stop) begin
            state      <= IDLE;
            al_set_pos <= 2'b00;
            snooze_cnt <= '0;
          end else if (sw_set) begin
            state      <= SET_MIN;
            al_set_pos <= 2'b01;
          end else if (sw_inc) begin
            al_hour <= (al_hour == 5'd23) ? 5'd0 : al_hour + 5'd1;
          end
        end
        SET_MIN: begin
          if (sw_stop || sw_set) begin
            state      <= IDLE;
            al_set_pos <= 2'b00;
            snooze_cnt <= '0;
          end else if (sw_inc) begin
            al_min <= (al_min == 6'd59) ? 6'd0 : al_min + 6'd1;
          end
        end
        RING: begin
          if (sw_stop) begin
            state      <= IDLE;
            ringing    <= 1'b0;
            buzzer     <= 1'b0;
            snooze_cnt <= '0;
          end else if (sw_inc && snooze_cnt != 2'd3) begin
            state      <= SNOOZE;
            ringing    <= 1'b0;
            buzzer     <= 1'b0;
            snooze_cnt <= snooze_cnt + 2'd1;
            snz_cnt    <= '0;
          end else if (tick1hz && ring_cnt == 6'd59) begin
            state      <= IDLE;
            ringing    <= 1'b0;
            buzzer     <= 1'b0;
            snooze_cnt <= '0;
          end else begin
            if (tick2hz) buzzer <= ~buzzer;
            if (tick1hz) ring_cnt <= ring_cnt + 6'd1;
          end
        end
        SNOOZE: begin
          if (sw_stop) begin
            state      <= IDLE;
            snooze_cnt <= '0;
          end else if (tick1hz && snz_cnt == 9'd299) begin
            state    <= RING;
            ringing  <= 1'b1;
            buzzer   <= 1'b1;
            ring_cnt <= '0;
          end else if (tick1hz) begin
            snz_cnt <= snz_cnt + 9'd1;
          end
        end
        default: begin
          state      <= IDLE;
          al_set_pos <= 2'b00;
          ringing    <= 1'b0;
          buzzer     <= 1'b0;
          snooze_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_unit.sv
// Bench for alarm_unit: directed scenarios plus random traffic,
// scoreboarded against a behavioural alarm-clock model.
module tb_alarm_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick1hz, tick2hz;
  logic       sw_set, sw_inc, sw_stop;
  logic [4:0] dc_hour;
  logic [5:0] dc_min, dc_sec;
  logic       mode;
  logic [4:0] al_hour;
  logic [5:0] al_min;
  logic       al_en;
  logic [1:0] al_set_pos;
  logic       ringing, buzzer;

  alarm_unit dut (
    .clk(clk), .reset(reset),
    .tick1hz(tick1hz), .tick2hz(tick2hz),
    .sw_set(sw_set), .sw_inc(sw_inc), .sw_stop(sw_stop),
    .dc_hour(dc_hour), .dc_min(dc_min), .dc_sec(dc_sec),
    .mode(mode),
    .al_hour(al_hour), .al_min(al_min), .al_en(al_en),
    .al_set_pos(al_set_pos), .ringing(ringing), .buzzer(buzzer)
  );

  always #5 clk = ~clk;

  // Model: activity 0 idle, 1 hour entry, 2 minute entry, 3 ringing, 4 snoozing
  int act, hr, mn, rsec, zsec, used;
  bit en, buz, prev;

  logic [15:0] exp_q[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;

  function automatic void to_idle();
    act = 0; buz = 0; used = 0;
  endfunction

  function automatic void start_ring();
    act = 3; buz = 1; rsec = 0;
  endfunction

  function automatic void model(input bit rst, s, i, p, t1, t2, md,
                                input int h, m, sc);
    bit hit, rise;
    if (!rst) begin
      act = 0; hr = 0; mn = 0; en = 0; buz = 0; prev = 0;
      rsec = 0; zsec = 0; used = 0;
      return;
    end
    hit  = en && !md && h == hr && m == mn && sc == 0;
    rise = hit && !prev;
    prev = hit;
    case (act)
      0: begin
        if (s) act = 1;
        else if (i) en = !en;
        else if (rise) start_ring();
      end
      1: begin
        if (p) to_idle();
        else if (s) act = 2;
        else if (i) hr = (hr + 1) % 24;
      end
      2: begin
        if (p || s) to_idle();
        else if (i) mn = (mn + 1) % 60;
      end
      3: begin
        if (p) to_idle();
        else if (i && used < 3) begin
          act = 4; used++; zsec = 0; buz = 0;
        end else begin
          if (t2) buz = !buz;
          if (t1) rsec++;
          if (rsec == 60) to_idle();
        end
      end
      default: begin
        if (p) to_idle();
        else begin
          if (t1) zsec++;
          if (zsec == 300) start_ring();
        end
      end
    endcase
  endfunction

  function automatic logic [15:0] expected();
    logic [1:0] pos;
    pos = (act == 1) ? 2'b10 : (act == 2) ? 2'b01 : 2'b00;
    return {5'(hr), 6'(mn), en, pos, act == 3, buz};
  endfunction

  task automatic step(input bit s, i, p, t1, t2);
    logic [15:0] e;
    sw_set = s; sw_inc = i; sw_stop = p;
    tick1hz = t1; tick2hz = t2;
    model(reset, s, i, p, t1, t2, mode,
          int'(dc_hour), int'(dc_min), int'(dc_sec));
    e = expected();
    @(posedge clk);
    exp_q.push_back(e);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0);
  endtask

  task automatic incs(input int n);
    for (int k = 0; k < n; k++) step(0, 1, 0, 0, 0);
  endtask

  task automatic set_time(input int h, m, sc);
    dc_hour = 5'(h); dc_min = 6'(m); dc_sec = 6'(sc);
  endtask

  task automatic set_0730();
    step(1, 0, 0, 0, 0);
    incs(7);
    step(1, 0, 0, 0, 0);
    incs(30);
    step(1, 0, 0, 0, 0);
  endtask

  task automatic fire();
    set_time(7, 29, 59);
    step(0, 0, 0, 0, 0);
    set_time(7, 30, 0);
    step(0, 0, 0, 0, 0);
    dc_sec = 6'd1;
  endtask

  task automatic snooze_wait();
    for (int k = 0; k < 300; k++) step(0, 0, 0, 1, k[0]);
  endtask

  always @(negedge clk) begin
    logic [15:0] e, got;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = {al_hour, al_min, al_en, al_set_pos, ringing, buzzer};
      tests++;
      if (got !== e) begin
        fails++;
        $display("FAIL outputs @%0t: got h=%0d m=%0d en=%b pos=%b ring=%b buz=%b, required h=%0d m=%0d en=%b pos=%b ring=%b buz=%b",
                 $time, got[15:11], got[10:5], got[4], got[3:2], got[1], got[0],
                 e[15:11], e[10:5], e[4], e[3:2], e[1], e[0]);
      end
    end
  end

  initial begin
    reset = 1'b0; mode = 1'b0;
    sw_set = 0; sw_inc = 0; sw_stop = 0;
    tick1hz = 0; tick2hz = 0;
    set_time(0, 0, 0);
    idle(2);
    reset = 1'b1;
    idle(2);

    // enter 07:30 and arm
    set_0730();
    step(0, 1, 0, 0, 0);
    idle(2);

    // wrap boundaries, set+inc together, abort from minute entry
    step(1, 0, 0, 0, 0);
    incs(16);
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    incs(29);
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    idle(2);
    set_time(12, 0, 30);
    set_0730();
    idle(2);

    // full ring to timeout
    fire();
    for (int k = 0; k < 245; k++) step(0, 0, 0, k % 4 == 3, k[0]);
    idle(3);

    // snooze three times, fourth ignored, then stop
    fire();
    idle(3);
    step(0, 1, 0, 0, 0);
    snooze_wait();
    step(0, 1, 0, 0, 1);
    snooze_wait();
    step(0, 1, 0, 0, 0);
    snooze_wait();
    step(0, 1, 0, 1, 1);
    idle(3);
    step(0, 0, 1, 0, 0);
    idle(2);

    // clock-setting mode suppresses, then stop wins over inc
    mode = 1'b1;
    fire();
    idle(3);
    mode = 1'b0;
    idle(2);
    fire();
    step(0, 1, 1, 0, 0);
    idle(2);

    // reset mid-ring, time stays on the match second
    fire();
    dc_sec = 6'd0;
    idle(3);
    reset = 1'b0;
    idle(1);
    reset = 1'b1;
    idle(5);

    // random traffic
    for (int c = 0; c < 15000; c++) begin
      reset = ($urandom_range(0, 999) != 0);
      mode  = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) != 0) begin
        dc_hour = 5'(hr); dc_min = 6'(mn);
      end else begin
        dc_hour = 5'($urandom_range(0, 23));
        dc_min  = 6'($urandom_range(0, 59));
      end
      dc_sec = ($urandom_range(0, 2) == 0) ? 6'd0 : 6'($urandom_range(1, 59));
      step($urandom_range(0, 59) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 199) == 0, $urandom_range(0, 1) == 0,
           $urandom_range(0, 2) == 0);
    end

    @(negedge clk);
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d pending, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alarm_unit.md
ALARM_UNIT -- requirements
Module: alarm_unit

Interface
REQ-001 clk  in  1  single system clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-low reset; sampled on rising clk edge.
REQ-003 tick1hz  in  1  one-clk-wide 1 Hz enable pulse from the clock-divider stage.
REQ-004 tick2hz  in  1  one-clk-wide 2 Hz enable pulse.
REQ-005 sw_set  in  1  debounced one-clk pulse: enter/advance alarm-setting position.
REQ-006 sw_inc  in  1  debounced one-clk pulse: increment field / toggle enable / snooze.
REQ-007 sw_stop  in  1  debounced one-clk pulse: silence alarm.
REQ-008 dc_hour  in  5  current hour 0..23 from the time-keeping stage.
REQ-009 dc_min  in  6  current minute 0..59.
REQ-010 dc_sec  in  6  current second 0..59.
REQ-011 mode  in  1  time-keeping mode; 1 = clock-setting mode.
REQ-012 al_hour  out  5  alarm hour 0..23.
REQ-013 al_min  out  6  alarm minute 0..59.
REQ-014 al_en  out  1  alarm armed.
REQ-015 al_set_pos  out  2  10 = setting hour, 01 = setting minute, 00 = not setting.
REQ-016 ringing  out  1  high in RING state.
REQ-017 buzzer  out  1  buzzer drive, 1 Hz square wave while ringing.

Function
REQ-018 FSM states: IDLE, SET_HOUR, SET_MIN, RING, SNOOZE; all outputs registered.
REQ-019 IDLE: sw_set -> SET_HOUR; sw_inc toggles al_en; no other change.
REQ-020 SET_HOUR: sw_inc -> al_hour+1, 23 wraps to 0; sw_set -> SET_MIN.
REQ-021 SET_MIN: sw_inc -> al_min+1, 59 wraps to 0; sw_set -> IDLE.
REQ-022 Set states: sw_set and sw_inc in same cycle -> transition only, no increment; sw_stop -> IDLE, values kept.
REQ-023 match = al_en & mode==0 & dc_hour==al_hour & dc_min==al_min & dc_sec==0; registered into match_d each cycle.
REQ-024 Trigger = match & ~match_d, evaluated only in IDLE; trigger -> RING next cycle; at most one trigger per matching second.
REQ-025 Match held while in set states does not trigger on return to IDLE unless match_d low (edge rule applies everywhere; match_d updates in every state).
REQ-026 RING entry: buzzer=1, ring_cnt=0; buzzer toggles on each tick2hz; ring_cnt +1 on each tick1hz.
REQ-027 RING: sw_stop -> IDLE; else sw_inc with snooze_cnt<3 -> SNOOZE, snooze_cnt+1, snz_cnt=0; sw_inc with snooze_cnt==3 ignored; else ring_cnt reaching 60 -> IDLE.
REQ-028 SNOOZE: snz_cnt (9 bits) +1 on each tick1hz; reaching 300 -> RING (re-entry per REQ-026); sw_stop -> IDLE.
REQ-029 Priority in every state: sw_stop > sw_set > sw_inc > counter timeouts.
REQ-030 snooze_cnt clears on every entry to IDLE.
REQ-031 buzzer = 0 and ringing = 0 in all states except RING; al_set_pos = 00 outside set states.
REQ-032 mode==1 suppresses trigger only; RING/SNOOZE already active continue.
REQ-033 Clearing al_en (not possible outside IDLE) therefore never aborts RING; sw_stop is the only manual abort.

Reset
REQ-034 reset==0 at a clk edge -> state IDLE, al_hour=0, al_min=0, al_en=0, al_set_pos=00, ringing=0, buzzer=0, all counters and match_d = 0, regardless of state, including mid-RING/SNOOZE.
REQ-035 First cycle after reset release behaves as IDLE with match_d=0.

Verification
REQ-036 Set alarm: sw_set, 7x sw_inc, sw_set, 30x sw_inc, sw_set, sw_inc -> al_hour=7, al_min=30, al_en=1, al_set_pos sequence 10,01,00.
REQ-037 Wrap: al_hour=23 + sw_inc in SET_HOUR -> 0; al_min=59 + sw_inc in SET_MIN -> 0.
REQ-038 Trigger: alarm 07:30 armed, time steps 07:29:59 -> 07:30:00 -> ringing=1 one cycle after match, buzzer toggles per tick2hz, returns IDLE after 60 tick1hz.
REQ-039 Snooze: in RING sw_inc -> SNOOZE, ringing=0; 300 tick1hz later ringing=1; 4th sw_inc in RING ignored; sw_stop -> IDLE.
REQ-040 Suppression: mode=1 at 07:30:00 -> no ring; same-cycle sw_stop+sw_inc in RING -> IDLE.
REQ-041 Reset mid-RING: reset=0 one cycle -> all outputs 0 next edge, no re-trigger while dc_sec remains 0 after release until match edge recurs.
